// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS control FSM
//
// Purpose: steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a
// shared datapath. It decodes opcode/funct into datapath selects and issues
// write strobes per state. Memory requests are held until mem_ready, and a
// watchdog moves to a sticky ERR state if a memory request stalls too long.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   opcode, funct       IR[31:26], IR[5:0]
//   isEqual             ALU compare result (used in EXEC of beq)
//   mem_ready           memory acknowledge for the pending request
//   mem_req, memWrite   memory request / store qualifier
//   isByte              byte access (lb/sb)
//   irWrite, pcWrite    IR / PC load strobes
//   NPCOp               next-PC select: 00 PC+4, 01 beq, 10 jal, 11 jr
//   regWrite            GRF write strobe
//   regDst, memToReg    GRF write-address / write-data selects
//   aluOp, aluSrc       ALU function / immediate operand select
//   extOp               1 = sign-extend immediate
//   state, err          FSM state (FETCH=0..WB=4, ERR=7), sticky error
//   instr_cnt           retired-instruction count
//
// Optional feature: define MC_INSTR_CNT_EN to build the retired-instruction
// counter. Without it, instr_cnt is tied to zero.

module multicycle_controller #(
  parameter int MEM_LAT_MAX = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             isEqual,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memWrite,
  output logic             isByte,
  output logic             irWrite,
  output logic             pcWrite,
  output logic [1:0]       NPCOp,
  output logic             regWrite,
  output logic [1:0]       regDst,
  output logic [1:0]       memToReg,
  output logic [2:0]       aluOp,
  output logic             aluSrc,
  output logic             extOp,
  output logic [2:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_e;

  localparam int WW = (MEM_LAT_MAX < 2) ? 1 : $clog2(MEM_LAT_MAX + 1);

  state_e          r_state;
  state_e          w_next;
  logic [WW-1:0]   r_wait_cnt;
  logic            w_wait;
  logic            w_timeout;

  logic w_add, w_sub, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_jal, w_lb, w_sb;
  logic w_load, w_store, w_alu;

  always_comb begin
    w_add   = (opcode == 6'h00) && (funct == 6'h20);
    w_sub   = (opcode == 6'h00) && (funct == 6'h22);
    w_jr    = (opcode == 6'h00) && (funct == 6'h08);
    w_ori   = (opcode == 6'h0d);
    w_lw    = (opcode == 6'h23);
    w_sw    = (opcode == 6'h2b);
    w_beq   = (opcode == 6'h04);
    w_lui   = (opcode == 6'h0f);
    w_jal   = (opcode == 6'h03);
    w_lb    = (opcode == 6'h20);
    w_sb    = (opcode == 6'h28);
    w_load  = w_lw | w_lb;
    w_store = w_sw | w_sb;
    w_alu   = w_add | w_sub | w_ori | w_lui;
  end

  // Datapath selects follow the IR in every state.
  always_comb begin
    regDst   = w_jal ? 2'b10 : ((w_add | w_sub) ? 2'b01 : 2'b00);
    memToReg = w_jal ? 2'b10 : (w_load ? 2'b01 : 2'b00);
    aluOp    = 3'b001;
    if (w_sub | w_beq) aluOp = 3'b000;
    else if (w_ori)    aluOp = 3'b010;
    else if (w_lui)    aluOp = 3'b011;
    aluSrc   = w_ori | w_lui | w_load | w_store;
    extOp    = w_load | w_store | w_beq;
    isByte   = w_lb | w_sb;
  end

  // A stall is any cycle with a request outstanding and no acknowledge.
  assign w_wait    = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  assign w_timeout = (MEM_LAT_MAX != 0) && w_wait &&
                     (32'(r_wait_cnt) == 32'(MEM_LAT_MAX - 1));

  always_comb begin
    w_next   = r_state;
    mem_req  = 1'b0;
    memWrite = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    NPCOp    = 2'b00;
    regWrite = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_DECODE: begin
        if (w_jal) begin
          // PC+4 is still in PC here, so the link write happens with the jump.
          pcWrite  = 1'b1;
          NPCOp    = 2'b10;
          regWrite = 1'b1;
          w_next   = S_FETCH;
        end else if (w_jr) begin
          pcWrite = 1'b1;
          NPCOp   = 2'b11;
          w_next  = S_FETCH;
        end else if (w_alu | w_load | w_store | w_beq) begin
          w_next = S_EXEC;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_EXEC: begin
        if (w_beq) begin
          pcWrite = isEqual;
          NPCOp   = 2'b01;
          w_next  = S_FETCH;
        end else if (w_load | w_store) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        memWrite = w_store;
        if (mem_ready)      w_next = w_load ? S_WB : S_FETCH;
        else if (w_timeout) w_next = S_ERR;
      end
      S_WB: begin
        regWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_FETCH;
    endcase
    if (reset) begin
      mem_req  = 1'b0;
      memWrite = 1'b0;
      irWrite  = 1'b0;
      pcWrite  = 1'b0;
      NPCOp    = 2'b00;
      regWrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= (w_wait && !w_timeout && (MEM_LAT_MAX != 0))
                    ? r_wait_cnt + WW'(1) : '0;
    end
  end

  assign state = r_state;
  assign err   = (r_state == S_ERR);

`ifdef MC_INSTR_CNT_EN
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_retire;

  // Every return to FETCH from a working state retires one instruction.
  assign w_retire = (r_state != S_FETCH) && (r_state != S_ERR) && (w_next == S_FETCH);

  always_ff @(posedge clk) begin
    if (reset)         r_instr_cnt <= '0;
    else if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
  end

  assign instr_cnt = r_instr_cnt;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller

module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        isEqual, mem_ready;
  logic        mem_req, memWrite, isByte, irWrite, pcWrite, regWrite, aluSrc, extOp, err;
  logic [1:0]  NPCOp, regDst, memToReg;
  logic [2:0]  aluOp, state;
  logic [31:0] instr_cnt;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_LAT_MAX(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .isEqual(isEqual),
    .mem_ready(mem_ready), .mem_req(mem_req), .memWrite(memWrite), .isByte(isByte),
    .irWrite(irWrite), .pcWrite(pcWrite), .NPCOp(NPCOp), .regWrite(regWrite),
    .regDst(regDst), .memToReg(memToReg), .aluOp(aluOp), .aluSrc(aluSrc),
    .extOp(extOp), .state(state), .err(err), .instr_cnt(instr_cnt)
  );

  typedef enum {K_ALU, K_LOAD, K_STORE, K_BEQ, K_JAL, K_JR, K_NOP} kind_e;
  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    kind_e      k;
    logic [9:0] dec;   // {regDst, memToReg, aluOp, aluSrc, extOp, isByte}
    logic [9:0] mask;  // aluOp is left free where no ALU function is defined
  } ins_t;

  typedef struct {
    logic [2:0] st;
    logic       rdy;
  } step_t;

  localparam logic [9:0] M_ALL = 10'h3ff;
  localparam logic [9:0] M_NOALU = 10'b11_11_000_111;

  ins_t tbl[12];
  int   n_checks = 0;
  int   n_errors = 0;
  int   model_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef MC_INSTR_CNT_EN
    return 32'(model_cnt);
`else
    return 32'd0;
`endif
  endfunction

  // {err, mem_req, memWrite, irWrite, pcWrite, regWrite, NPCOp}
  function automatic logic [7:0] exp_stb(input kind_e k, input logic [2:0] st,
                                         input logic rdy, input logic eq);
    case (st)
      3'd0: return {1'b0, 1'b1, 1'b0, rdy, rdy, 1'b0, 2'b00};
      3'd1: begin
        if (k == K_JAL) return 8'b0_0_0_0_1_1_10;
        if (k == K_JR)  return 8'b0_0_0_0_1_0_11;
        return 8'h00;
      end
      3'd2: return (k == K_BEQ) ? {1'b0, 1'b0, 1'b0, 1'b0, eq, 1'b0, 2'b01} : 8'h00;
      3'd3: return {1'b0, 1'b1, (k == K_STORE), 1'b0, 1'b0, 1'b0, 2'b00};
      3'd4: return 8'b0_0_0_0_0_1_00;
      3'd7: return 8'b1_0_0_0_0_0_00;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] obs_stb();
    return {err, mem_req, memWrite, irWrite, pcWrite, regWrite, NPCOp};
  endfunction

  function automatic logic [9:0] obs_dec();
    return {regDst, memToReg, aluOp, aluSrc, extOp, isByte};
  endfunction

  // Entered just after a negedge: drive, settle, check, advance to next negedge.
  task automatic step(input int idx, input step_t s, input logic eq);
    mem_ready = s.rdy;
    isEqual   = eq;
    #1;
    check_eq($sformatf("%s.state", tbl[idx].name), 32'(state), 32'(s.st));
    check_eq($sformatf("%s.stb@%0d", tbl[idx].name, s.st), 32'(obs_stb()),
             32'(exp_stb(tbl[idx].k, s.st, s.rdy, eq)));
    check_eq($sformatf("%s.dec", tbl[idx].name), 32'(obs_dec() & tbl[idx].mask),
             32'(tbl[idx].dec & tbl[idx].mask));
    @(negedge clk);
  endtask

  task automatic run_instr(input int idx, input int wf, input int wm, input logic eq);
    step_t q[$];
    kind_e k = tbl[idx].k;
    opcode = tbl[idx].op;
    funct  = (tbl[idx].op == 6'h00) ? tbl[idx].fn : 6'($urandom);
    for (int i = 0; i < wf; i++) q.push_back('{3'd0, 1'b0});
    q.push_back('{3'd0, 1'b1});
    q.push_back('{3'd1, 1'($urandom)});
    if (k == K_BEQ) q.push_back('{3'd2, 1'($urandom)});
    if (k == K_ALU) begin
      q.push_back('{3'd2, 1'($urandom)});
      q.push_back('{3'd4, 1'($urandom)});
    end
    if (k == K_LOAD || k == K_STORE) begin
      q.push_back('{3'd2, 1'($urandom)});
      for (int i = 0; i < wm; i++) q.push_back('{3'd3, 1'b0});
      q.push_back('{3'd3, 1'b1});
      if (k == K_LOAD) q.push_back('{3'd4, 1'($urandom)});
    end
    #1;
    check_eq($sformatf("%s.cnt", tbl[idx].name), instr_cnt, exp_cnt());
    foreach (q[i]) step(idx, q[i], eq);
    model_cnt++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    check_eq("rst.stb", 32'(obs_stb() & 8'h7f), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b0;
    #1;
    check_eq("rst.state", 32'(state), 32'd0);
    check_eq("rst.err", 32'(err), 32'd0);
    check_eq("rst.memWrite", 32'(memWrite), 32'd0);
    model_cnt = 0;
    check_eq("rst.cnt", instr_cnt, exp_cnt());
  endtask

  function automatic int rnd_wait();
    return ($urandom_range(0, 7) == 0) ? 7 : int'($urandom_range(0, 2));
  endfunction

  initial begin
    tbl[0]  = '{"add", 6'h00, 6'h20, K_ALU,   10'b01_00_001_0_0_0, M_ALL};
    tbl[1]  = '{"sub", 6'h00, 6'h22, K_ALU,   10'b01_00_000_0_0_0, M_ALL};
    tbl[2]  = '{"jr",  6'h00, 6'h08, K_JR,    10'b00_00_000_0_0_0, M_NOALU};
    tbl[3]  = '{"ori", 6'h0d, 6'h00, K_ALU,   10'b00_00_010_1_0_0, M_ALL};
    tbl[4]  = '{"lw",  6'h23, 6'h00, K_LOAD,  10'b00_01_001_1_1_0, M_ALL};
    tbl[5]  = '{"sw",  6'h2b, 6'h00, K_STORE, 10'b00_00_001_1_1_0, M_ALL};
    tbl[6]  = '{"beq", 6'h04, 6'h00, K_BEQ,   10'b00_00_000_0_1_0, M_ALL};
    tbl[7]  = '{"lui", 6'h0f, 6'h00, K_ALU,   10'b00_00_011_1_0_0, M_ALL};
    tbl[8]  = '{"jal", 6'h03, 6'h00, K_JAL,   10'b10_10_000_0_0_0, M_NOALU};
    tbl[9]  = '{"lb",  6'h20, 6'h00, K_LOAD,  10'b00_01_001_1_1_1, M_ALL};
    tbl[10] = '{"sb",  6'h28, 6'h00, K_STORE, 10'b00_00_001_1_1_1, M_ALL};
    tbl[11] = '{"nop", 6'h02, 6'h00, K_NOP,   10'b00_00_000_0_0_0, M_NOALU};

    reset = 1'b1; opcode = 6'h0d; funct = 6'h00; isEqual = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    run_instr(3, 0, 0, 1'b0);   // ori, no waits
    run_instr(4, 0, 3, 1'b0);   // lw, ack three cycles late in MEM
    run_instr(6, 0, 0, 1'b0);   // beq not taken
    run_instr(6, 0, 0, 1'b1);   // beq taken
    run_instr(8, 0, 0, 1'b0);   // jal
    run_instr(2, 1, 0, 1'b0);   // jr
    run_instr(11, 0, 0, 1'b0);  // unknown opcode
    for (int n = 0; n < 80; n++)
      run_instr(int'($urandom_range(0, 11)), rnd_wait(), rnd_wait(), 1'($urandom));
    run_instr(9, 7, 7, 1'b0);   // longest stall that must not trip the watchdog

    // Reset while an sb is waiting in MEM abandons it.
    opcode = 6'h28; funct = 6'($urandom);
    step(10, '{3'd0, 1'b1}, 1'b0);
    step(10, '{3'd1, 1'b0}, 1'b0);
    step(10, '{3'd2, 1'b0}, 1'b0);
    step(10, '{3'd3, 1'b0}, 1'b0);
    do_reset();

    // Watchdog: fetch never acknowledged.
    opcode = 6'h0d;
    for (int i = 0; i < 8; i++) begin
      mem_ready = 1'b0;
      #1;
      check_eq("wd.wait_state", 32'(state), 32'd0);
      check_eq("wd.wait_req", 32'(mem_req), 32'd1);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom);
      #1;
      check_eq("wd.state", 32'(state), 32'd7);
      check_eq("wd.stb", 32'(obs_stb()), 32'h80);
      check_eq("wd.cnt", instr_cnt, exp_cnt());
      @(negedge clk);
    end
    do_reset();
    run_instr(0, 0, 0, 1'b0);   // add after recovery

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
